// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped line cache controller.
package cache_pkg;

    localparam int S_OFFSET   = 5;
    localparam int S_INDEX    = 4;
    localparam int S_TAG      = 32 - S_OFFSET - S_INDEX;
    localparam int NUM_SETS   = 1 << S_INDEX;
    localparam int LINE_BITS  = 256;
    localparam int LINE_BYTES = LINE_BITS / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

endpackage

// File: rtl/cache_tag_array.sv
// Per-set tag, valid and dirty state with a combinational read port.
// Reads and updates share one index because the controller only ever
// touches the set addressed by the current request.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] index,
    input  logic               load,
    input  logic [S_TAG-1:0]   load_tag,
    input  logic               set_dirty,
    input  logic               clr_dirty,
    output logic [S_TAG-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty
);

    logic [S_TAG-1:0]    tag_q [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

    // Update the addressed set; a line load also cleans it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                tag_q[i] <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (load) begin
                tag_q[index]   <= load_tag;
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end else if (set_dirty) begin
                dirty_q[index] <= 1'b1;
            end else if (clr_dirty) begin
                dirty_q[index] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller. Hits are
// served combinationally in IDLE; misses write back a dirty victim and
// then fill the line from memory before completing as a hit.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [LINE_BYTES-1:0] mem_byte_enable256,
    input  logic [LINE_BITS-1:0]  mem_wdata256,
    output logic [LINE_BITS-1:0]  mem_rdata256,
    output logic                  mem_resp,
    output logic [31:0]           pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_BITS-1:0]  pmem_wdata,
    input  logic [LINE_BITS-1:0]  pmem_rdata,
    input  logic                  pmem_resp,
    output logic [LINE_BYTES-1:0] array_write_en,
    output logic [S_INDEX-1:0]    array_rindex,
    output logic [S_INDEX-1:0]    array_windex,
    output logic [LINE_BITS-1:0]  array_datain,
    input  logic [LINE_BITS-1:0]  array_dataout
);

    state_e state_q, state_d;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [S_TAG-1:0]   set_tag;
    logic               set_valid;
    logic               set_is_dirty;
    logic               hit;
    logic               req_valid;
    logic               tag_load;
    logic               tag_set_dirty;
    logic               tag_clr_dirty;
    logic               unused_offset;

    assign req_tag       = mem_address[31:S_OFFSET+S_INDEX];
    assign req_index     = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign unused_offset = ^mem_address[S_OFFSET-1:0];

    assign req_valid    = mem_read | mem_write;
    assign hit          = set_valid && (set_tag == req_tag);

    // The data array is always addressed by the request's set.
    assign array_rindex = req_index;
    assign array_windex = req_index;
    assign mem_rdata256 = array_dataout;
    assign pmem_wdata   = array_dataout;

    cache_tag_array u_tags (
        .clk       (clk),
        .rst       (rst),
        .index     (req_index),
        .load      (tag_load),
        .load_tag  (req_tag),
        .set_dirty (tag_set_dirty),
        .clr_dirty (tag_clr_dirty),
        .rd_tag    (set_tag),
        .rd_valid  (set_valid),
        .rd_dirty  (set_is_dirty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all strobes; everything is forced idle while reset
    // is low so an aborted memory transaction drops without a clock edge.
    always_comb begin
        state_d        = state_q;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = {req_tag, req_index, {S_OFFSET{1'b0}}};
        array_write_en = '0;
        array_datain   = mem_wdata256;
        tag_load       = 1'b0;
        tag_set_dirty  = 1'b0;
        tag_clr_dirty  = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (hit) begin
                            mem_resp = 1'b1;
                            // A simultaneous read and write is served as a write.
                            if (mem_write) begin
                                array_write_en = mem_byte_enable256;
                                tag_set_dirty  = 1'b1;
                            end
                        end else if (set_is_dirty) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {set_tag, req_index, {S_OFFSET{1'b0}}};
                    if (pmem_resp) begin
                        tag_clr_dirty = 1'b1;
                        state_d       = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        array_write_en = '1;
                        array_datain   = pmem_rdata;
                        tag_load       = 1'b1;
                        state_d        = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flag requesters that raise read and write together.
    assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write))
        else $warning("cache_ctrl: mem_read and mem_write asserted together, serviced as write");

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl with a behavioural data array and a
// fixed-latency line memory.
module tb_cache_ctrl;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  array_write_en;
    logic [3:0]   array_rindex;
    logic [3:0]   array_windex;
    logic [255:0] array_datain;
    logic [255:0] array_dataout;

    int errors = 0;
    int checks = 0;

    cache_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .mem_address        (mem_address),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_byte_enable256 (mem_byte_enable256),
        .mem_wdata256       (mem_wdata256),
        .mem_rdata256       (mem_rdata256),
        .mem_resp           (mem_resp),
        .pmem_address       (pmem_address),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp),
        .array_write_en     (array_write_en),
        .array_rindex       (array_rindex),
        .array_windex       (array_windex),
        .array_datain       (array_datain),
        .array_dataout      (array_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data array: combinational read, byte-enabled synchronous write.
    logic [255:0] darr [16];
    assign array_dataout = darr[array_rindex];
    always @(posedge clk) begin
        for (int b = 0; b < 32; b++) begin
            if (array_write_en[b]) darr[array_windex][b*8 +: 8] <= array_datain[b*8 +: 8];
        end
    end

    // Line memory: answers any strobe after a fixed delay and logs it.
    logic [255:0] fill_data;
    int           lat_cnt = 0;
    int           fill_count = 0;
    int           wb_count = 0;
    int           seq = 0;
    int           fill_seq = 0;
    int           wb_seq = 0;
    logic [31:0]  fill_addr = '0;
    logic [31:0]  wb_addr = '0;
    logic [255:0] wb_data = '0;
    assign pmem_rdata = fill_data;
    initial pmem_resp = 1'b0;
    always @(posedge clk) begin
        pmem_resp <= 1'b0;
        if ((pmem_read || pmem_write) && !pmem_resp) begin
            if (lat_cnt == 2) begin
                pmem_resp <= 1'b1;
                lat_cnt   <= 0;
                seq       <= seq + 1;
                if (pmem_write) begin
                    wb_count <= wb_count + 1;
                    wb_addr  <= pmem_address;
                    wb_data  <= pmem_wdata;
                    wb_seq   <= seq + 1;
                end else begin
                    fill_count <= fill_count + 1;
                    fill_addr  <= pmem_address;
                    fill_seq   <= seq + 1;
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    // Issue one request and hold it until mem_resp (bounded).
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] be, input logic [255:0] wd,
                          output int lat, output logic [255:0] rdata);
        @(negedge clk);
        mem_read           = rd;
        mem_write          = wr;
        mem_address        = addr;
        mem_byte_enable256 = be;
        mem_wdata256       = wd;
        #1;
        lat = 0;
        while (!mem_resp && lat < 60) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!mem_resp) begin
            errors++;
            $display("FAIL req_timeout addr=%h: mem_resp=%b after %0d cycles, required 1", addr, mem_resp, lat);
        end
        rdata = mem_rdata256;
        $display("req rd=%b wr=%b addr=%h latency=%0d", rd, wr, addr, lat);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || array_write_en !== 32'h0) begin
            errors++;
            $display("FAIL reset_initial: resp/rd/wr=%b%b%b we=%h, required 000 and 0", mem_resp, pmem_read, pmem_write, array_write_en);
        end
        @(negedge clk) rst = 1'b1;
        // Start a miss, then pull reset in the middle of the fill.
        @(negedge clk);
        mem_address = 32'h0000_1040;
        mem_read    = 1'b1;
        n = 0;
        while (!pmem_read && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_midrun_setup: pmem_read=%b, required 1", pmem_read);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || array_write_en !== 32'h0) begin
            errors++;
            $display("FAIL reset_midrun: resp/rd/wr=%b%b%b we=%h, required 000 and 0", mem_resp, pmem_read, pmem_write, array_write_en);
        end
        mem_read = 1'b0;
        @(negedge clk) rst = 1'b1;
        $display("reset checks done");
    endtask

    task automatic test_cold_miss();
        int lat;
        logic [255:0] rd;
        int f0, w0;
        fill_data = {32{8'hA5}};
        f0 = fill_count;
        w0 = wb_count;
        do_req(1'b1, 1'b0, 32'h0000_1040, 32'h0, 256'h0, lat, rd);
        checks++;
        // One decision cycle plus four cycles of pmem_read.
        if (lat !== 5) begin errors++; $display("FAIL cold_latency: got %0d, required 5", lat); end
        checks++;
        if (rd !== {32{8'hA5}}) begin errors++; $display("FAIL cold_rdata: got %h, required all a5", rd); end
        checks++;
        if (fill_count - f0 !== 1 || wb_count - w0 !== 0) begin
            errors++; $display("FAIL cold_pmem_count: fills=%0d wbs=%0d, required 1 and 0", fill_count - f0, wb_count - w0);
        end
        checks++;
        if (fill_addr !== 32'h0000_1040) begin errors++; $display("FAIL cold_fill_addr: got %h, required 00001040", fill_addr); end
    endtask

    task automatic test_write_hit();
        int lat;
        logic [255:0] rd;
        int f0, w0;
        f0 = fill_count;
        w0 = wb_count;
        do_req(1'b0, 1'b1, 32'h0000_1040, 32'h0000_000F, {32{8'h11}}, lat, rd);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL write_hit_latency: got %0d, required 0", lat); end
        do_req(1'b1, 1'b0, 32'h0000_1040, 32'h0, 256'h0, lat, rd);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL read_hit_latency: got %0d, required 0", lat); end
        checks++;
        if (rd !== {{28{8'hA5}}, {4{8'h11}}}) begin errors++; $display("FAIL merged_rdata: got %h", rd); end
        checks++;
        if (fill_count !== f0 || wb_count !== w0) begin
            errors++; $display("FAIL hit_no_pmem: fills=%0d wbs=%0d, required %0d %0d", fill_count, wb_count, f0, w0);
        end
    endtask

    task automatic test_dirty_evict();
        int lat;
        logic [255:0] rd;
        int f0, w0;
        fill_data = {32{8'h5A}};
        f0 = fill_count;
        w0 = wb_count;
        do_req(1'b1, 1'b0, 32'h0000_3040, 32'h0, 256'h0, lat, rd);
        checks++;
        if (wb_count - w0 !== 1 || fill_count - f0 !== 1) begin
            errors++; $display("FAIL evict_counts: wbs=%0d fills=%0d, required 1 and 1", wb_count - w0, fill_count - f0);
        end
        checks++;
        if (wb_addr !== 32'h0000_1040) begin errors++; $display("FAIL evict_wb_addr: got %h, required 00001040", wb_addr); end
        checks++;
        if (wb_data !== {{28{8'hA5}}, {4{8'h11}}}) begin errors++; $display("FAIL evict_wb_data: got %h", wb_data); end
        checks++;
        if (fill_addr !== 32'h0000_3040) begin errors++; $display("FAIL evict_fill_addr: got %h, required 00003040", fill_addr); end
        checks++;
        if (!(wb_seq < fill_seq)) begin errors++; $display("FAIL evict_order: wb_seq=%0d fill_seq=%0d, required wb first", wb_seq, fill_seq); end
        checks++;
        if (rd !== {32{8'h5A}}) begin errors++; $display("FAIL evict_rdata: got %h, required all 5a", rd); end
    endtask

    task automatic test_reset_fill();
        int lat, n;
        logic [255:0] rd;
        logic [255:0] snap;
        int f0, w0;
        // Make index 2 dirty, then miss on it so a writeback precedes the fill.
        do_req(1'b0, 1'b1, 32'h0000_3040, 32'hFFFF_FFFF, {32{8'hC3}}, lat, rd);
        fill_data = {32{8'h77}};
        @(negedge clk);
        mem_address = 32'h0000_5040;
        mem_read    = 1'b1;
        n = 0;
        while (!pmem_read && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pmem_read !== 1'b1) begin errors++; $display("FAIL rfill_setup: pmem_read=%b, required 1", pmem_read); end
        snap = darr[2];
        #3 rst = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || array_write_en !== 32'h0) begin
            errors++; $display("FAIL rfill_abort: pmem_read=%b we=%h, required 0 and 0", pmem_read, array_write_en);
        end
        mem_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (darr[2] !== snap) begin errors++; $display("FAIL rfill_array: got %h, required %h", darr[2], snap); end
        @(negedge clk) rst = 1'b1;
        fill_data = {32{8'h6E}};
        f0 = fill_count;
        w0 = wb_count;
        do_req(1'b1, 1'b0, 32'h0000_3040, 32'h0, 256'h0, lat, rd);
        checks++;
        if (wb_count !== w0 || fill_count - f0 !== 1) begin
            errors++; $display("FAIL rfill_clean_miss: wbs=%0d fills=%0d, required 0 and 1", wb_count - w0, fill_count - f0);
        end
        checks++;
        if (rd !== {32{8'h6E}}) begin errors++; $display("FAIL rfill_rdata: got %h, required all 6e", rd); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [255:0] rd;
        logic [31:0] addrs [3];
        int f0, w0;
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0020;
        addrs[2] = 32'h0000_01E0;
        fill_data = {32{8'h3C}};
        for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, addrs[i], 32'h0, 256'h0, lat, rd);
        f0 = fill_count;
        w0 = wb_count;
        do_req(1'b0, 1'b1, addrs[0], 32'hFFFF_FFFF, {32{8'h77}}, lat, rd);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL b2b_wr0_latency: got %0d, required 0", lat); end
        do_req(1'b1, 1'b0, addrs[1], 32'h0, 256'h0, lat, rd);
        checks++;
        if (lat !== 0 || rd !== {32{8'h3C}}) begin errors++; $display("FAIL b2b_rd1: lat=%0d data=%h, required 0 and all 3c", lat, rd); end
        do_req(1'b1, 1'b1, addrs[2], 32'hFFFF_0000, {32{8'h99}}, lat, rd);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL b2b_rdwr15_latency: got %0d, required 0", lat); end
        do_req(1'b1, 1'b0, addrs[2], 32'h0, 256'h0, lat, rd);
        checks++;
        if (lat !== 0 || rd !== {{16{8'h99}}, {16{8'h3C}}}) begin
            errors++; $display("FAIL b2b_rd15: lat=%0d data=%h, required 0 and upper 99 lower 3c", lat, rd);
        end
        do_req(1'b1, 1'b0, addrs[0], 32'h0, 256'h0, lat, rd);
        checks++;
        if (lat !== 0 || rd !== {32{8'h77}}) begin errors++; $display("FAIL b2b_rd0: lat=%0d data=%h, required 0 and all 77", lat, rd); end
        checks++;
        if (fill_count !== f0 || wb_count !== w0) begin
            errors++; $display("FAIL b2b_no_pmem: fills=%0d wbs=%0d, required %0d %0d", fill_count, wb_count, f0, w0);
        end
    endtask

    initial begin
        mem_address        = '0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_byte_enable256 = '0;
        mem_wdata256       = '0;
        fill_data          = '0;
        test_reset();
        test_cold_miss();
        test_write_hit();
        test_dirty_evict();
        test_reset_fill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
